// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, FSM states and status flags.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: loads on start, runs WIDTH iterations.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic                r_busy;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic                w_last;

  // product is the post-iteration sum so the consumer can capture it on the final edge
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign busy    = r_busy;
  assign done    = w_last;
  assign product = w_acc_next;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with one registered output slot; MUL runs on an iterative sub-unit.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e         r_state, w_state_next;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out, r_out_hi;
  alu_flags_t         r_flags;

  alu_op_e            w_op;
  logic               w_accept, w_mul_start, w_mul_busy, w_mul_done;
  logic               w_load_alu, w_load_mul;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_res_flags, w_mul_flags;
  logic [WIDTH:0]     w_add, w_sub, w_shl;
  logic [SW-1:0]      w_sh;

  assign w_op        = alu_op_e'(op_in);
  assign in_ready    = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_op == OP_MUL);

  assign w_add = {1'b0, a_in} + {1'b0, b_in};
  assign w_sub = {1'b0, a_in} - {1'b0, b_in};
  assign w_sh  = b_in[SW-1:0];
  // the extra top bit catches the last bit shifted out
  assign w_shl = {1'b0, a_in} << w_sh;

  always_comb begin
    w_res       = '0;
    w_res_flags = '0;
    case (w_op)
      OP_ADD: begin
        w_res         = w_add[WIDTH-1:0];
        w_res_flags.c = w_add[WIDTH];
        w_res_flags.v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (w_add[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        w_res         = w_sub[WIDTH-1:0];
        w_res_flags.c = w_sub[WIDTH];
        w_res_flags.v = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (w_sub[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND: w_res = a_in & b_in;
      OP_OR:  w_res = a_in | b_in;
      OP_XOR: w_res = a_in ^ b_in;
      OP_SLT: w_res = WIDTH'($signed(a_in) < $signed(b_in));
      OP_SHL: begin
        w_res         = w_shl[WIDTH-1:0];
        w_res_flags.c = w_shl[WIDTH];
      end
      default: w_res = '0;
    endcase
    w_res_flags.n = w_res[WIDTH-1];
    w_res_flags.z = (w_res == '0);
  end

  always_comb begin
    w_mul_flags   = '0;
    w_mul_flags.n = w_product[WIDTH-1];
    w_mul_flags.z = (w_product[WIDTH-1:0] == '0);
    w_mul_flags.c = (w_product[2*WIDTH-1:WIDTH] != '0);
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (a_in),
    .b       (b_in),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_comb begin
    w_state_next = r_state;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) w_state_next = MUL;
          else                w_load_alu   = 1'b1;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_load_mul   = 1'b1;
          w_state_next = IDLE;
        end else if (!w_mul_busy) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_flags     <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_load_alu) begin
        r_out       <= w_res;
        r_out_hi    <= '0;
        r_flags     <= w_res_flags;
        r_out_valid <= 1'b1;
      end else if (w_load_mul) begin
        r_out       <= w_product[WIDTH-1:0];
        r_out_hi    <= w_product[2*WIDTH-1:WIDTH];
        r_flags     <= w_mul_flags;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign out_hi    = r_out_hi;
  assign flags     = r_flags;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH=4 and WIDTH=8 instances, vector table plus scoreboard queues.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, iv4, ir4, ov4, or4;
  logic [2:0] op4;
  logic [3:0] a4, b4, out4, hi4, fl4;

  logic       rst8, iv8, ir8, ov8, or8;
  logic [2:0] op8;
  logic [7:0] a8, b8, out8, hi8;
  logic [3:0] fl8;

  alu_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .op_in(op4), .a_in(a4), .b_in(b4),
    .in_valid(iv4), .in_ready(ir4), .out(out4), .out_hi(hi4),
    .flags(fl4), .out_valid(ov4), .out_ready(or4)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .op_in(op8), .a_in(a8), .b_in(b8),
    .in_valid(iv8), .in_ready(ir8), .out(out8), .out_hi(hi8),
    .flags(fl8), .out_valid(ov8), .out_ready(or8)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, out, hi;
    logic [3:0] fl;
  } vec_t;

  typedef struct {
    logic [7:0] out, hi;
    logic [3:0] fl;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // sel 0 drives the 4-bit DUT, 1 the 8-bit DUT; returns after the accept edge (+1)
  task automatic send(input int sel, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input exp_t e, input logic push, output int waits);
    logic rdy;
    if (sel == 0) begin op4 = op; a4 = a[3:0]; b4 = b[3:0]; iv4 = 1'b1; end
    else          begin op8 = op; a8 = a;      b8 = b;      iv8 = 1'b1; end
    waits = 0;
    @(negedge clk);
    rdy = (sel == 0) ? ir4 : ir8;
    while (!rdy && waits < 50) begin
      waits++;
      @(negedge clk);
      rdy = (sel == 0) ? ir4 : ir8;
    end
    if (!rdy) check("accept_timeout", {31'd0, rdy}, 32'd1);
    if (push) begin
      if (sel == 0) q4.push_back(e);
      else          q8.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel == 0) iv4 = 1'b0;
    else          iv8 = 1'b0;
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst4 && ov4 && or4) begin
      check("q4_has_entry", {31'd0, q4.size() != 0}, 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("out4", {28'd0, out4}, {24'd0, e.out});
        check("hi4", {28'd0, hi4}, {24'd0, e.hi});
        check("flags4", {28'd0, fl4}, {28'd0, e.fl});
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst8 && ov8 && or8) begin
      check("q8_has_entry", {31'd0, q8.size() != 0}, 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("out8", {24'd0, out8}, {24'd0, e.out});
        check("hi8", {24'd0, hi8}, {24'd0, e.hi});
        check("flags8", {28'd0, fl8}, {28'd0, e.fl});
      end
    end
  end

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q4.size() : q8.size()) != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check((sel == 0) ? "q4_drained" : "q8_drained",
          (sel == 0) ? q4.size() : q8.size(), 32'd0);
  endtask

  vec_t tbl[18];
  exp_t e;
  int   w0, w1, seen;

  initial begin
    // {op, a, b, out, hi, flags{n,z,c,v}} for WIDTH=4
    tbl[0]  = '{3'b000, 8'h9, 8'h6, 8'hF, 8'h0, 4'b1000};
    tbl[1]  = '{3'b001, 8'h1, 8'h3, 8'hE, 8'h0, 4'b1010};
    tbl[2]  = '{3'b000, 8'h7, 8'h1, 8'h8, 8'h0, 4'b1001};
    tbl[3]  = '{3'b010, 8'hC, 8'hA, 8'h8, 8'h0, 4'b1000};
    tbl[4]  = '{3'b011, 8'h3, 8'h4, 8'h7, 8'h0, 4'b0000};
    tbl[5]  = '{3'b100, 8'hA, 8'h5, 8'hF, 8'h0, 4'b1000};
    tbl[6]  = '{3'b100, 8'h5, 8'h5, 8'h0, 8'h0, 4'b0100};
    tbl[7]  = '{3'b101, 8'h8, 8'h1, 8'h1, 8'h0, 4'b0000};
    tbl[8]  = '{3'b101, 8'h1, 8'h8, 8'h0, 8'h0, 4'b0100};
    tbl[9]  = '{3'b110, 8'h3, 8'h3, 8'h8, 8'h0, 4'b1010};
    tbl[10] = '{3'b110, 8'h5, 8'h0, 8'h5, 8'h0, 4'b0000};
    tbl[11] = '{3'b110, 8'hC, 8'h5, 8'h8, 8'h0, 4'b1010};
    tbl[12] = '{3'b000, 8'h8, 8'h8, 8'h0, 8'h0, 4'b0111};
    tbl[13] = '{3'b001, 8'h8, 8'h1, 8'h7, 8'h0, 4'b0001};
    tbl[14] = '{3'b111, 8'hF, 8'hF, 8'h1, 8'hE, 4'b0010};
    tbl[15] = '{3'b111, 8'h3, 8'h5, 8'hF, 8'h0, 4'b1000};
    tbl[16] = '{3'b111, 8'h0, 8'h7, 8'h0, 8'h0, 4'b0100};
    tbl[17] = '{3'b001, 8'h5, 8'h5, 8'h0, 8'h0, 4'b0100};

    rst4 = 1'b1; iv4 = 1'b0; or4 = 1'b1; op4 = '0; a4 = '0; b4 = '0;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    @(posedge clk);
    #1;
    check("rst_ov4", {31'd0, ov4}, 32'd0);
    check("rst_out4", {28'd0, out4}, 32'd0);
    check("rst_flags4", {28'd0, fl4}, 32'd0);
    check("rst_ir4", {31'd0, ir4}, 32'd0);
    @(posedge clk);
    #1;
    rst4 = 1'b0; rst8 = 1'b0;
    #1;
    check("post_rst_ir4", {31'd0, ir4}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      e = '{tbl[i].out, tbl[i].hi, tbl[i].fl};
      send(0, tbl[i].op, tbl[i].a, tbl[i].b, e, 1'b1, w0);
    end
    drain(0);

    // back-to-back accepts with out_ready held high
    send(0, 3'b001, 8'h1, 8'h3, '{8'hE, 8'h0, 4'b1010}, 1'b1, w0);
    send(0, 3'b000, 8'h7, 8'h1, '{8'h8, 8'h0, 4'b1001}, 1'b1, w1);
    check("b2b_wait0", w0, 32'd0);
    check("b2b_wait1", w1, 32'd0);
    drain(0);

    // MUL latency: slot empty and in_ready low for WIDTH cycles after accept
    send(0, 3'b111, 8'hF, 8'hF, '{8'h1, 8'hE, 4'b0010}, 1'b1, w0);
    for (int i = 0; i < 4; i++) begin
      check("mul_ir_low", {31'd0, ir4}, 32'd0);
      check("mul_ov_low", {31'd0, ov4}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("mul_ov_high", {31'd0, ov4}, 32'd1);
    drain(0);

    // backpressure hold, then drain and accept in the same cycle
    or4 = 1'b0;
    send(0, 3'b100, 8'hA, 8'h5, '{8'hF, 8'h0, 4'b1000}, 1'b1, w0);
    for (int i = 0; i < 3; i++) begin
      check("bp_ov", {31'd0, ov4}, 32'd1);
      check("bp_out", {28'd0, out4}, 32'hF);
      check("bp_ir", {31'd0, ir4}, 32'd0);
      @(posedge clk);
      #1;
    end
    or4 = 1'b1;
    send(0, 3'b010, 8'hF, 8'h3, '{8'h3, 8'h0, 4'b0000}, 1'b1, w1);
    check("bp_release_wait", w1, 32'd0);
    drain(0);

    // WIDTH=8 sanity
    send(1, 3'b000, 8'd200, 8'd100, '{8'h2C, 8'h00, 4'b0010}, 1'b1, w0);
    send(1, 3'b111, 8'd200, 8'd3, '{8'h58, 8'h02, 4'b0010}, 1'b1, w0);
    drain(1);

    // reset during MUL cycle 2 abandons the multiply
    send(1, 3'b111, 8'd200, 8'd3, '{8'h0, 8'h0, 4'b0000}, 1'b0, w0);
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    check("ir8_in_reset", {31'd0, ir8}, 32'd0);
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    #1;
    check("rst8_ov", {31'd0, ov8}, 32'd0);
    check("rst8_flags", {28'd0, fl8}, 32'd0);
    check("rst8_out", {24'd0, out8}, 32'd0);
    check("rst8_hi", {24'd0, hi8}, 32'd0);
    check("rst8_ir_idle", {31'd0, ir8}, 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("no_stray8", seen, 32'd0);
    send(1, 3'b000, 8'd0, 8'd0, '{8'h0, 8'h0, 4'b0100}, 1'b1, w0);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
